prefetch_queue: RTL and testbench



---
 rtl/prefetch_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_prefetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// ---------------------------------------------------------------------------
// prefetch_queue
//
// Instruction prefetch unit sitting between the program-memory arbiter and
// the decoder. It keeps a DEPTH-entry FIFO of fetched instruction words, each
// tagged with its PC, and fetches sequentially while there is room. At most
// one memory request is outstanding at a time. A redirect flushes the FIFO,
// reloads the fetch PC and drops any response that is still in flight.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   Defined   : when the FIFO is empty and the response arrives, the word is
//               presented on instr/instr_pc/instr_valid in the same cycle; a
//               take in that cycle consumes it without writing the FIFO.
//   Undefined : outputs come only from the FIFO head (one cycle of latency).
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   mem_req      out  fetch request, held until mem_ready
//   mem_addr     out  fetch address, stable while mem_req is high
//   mem_busy     in   arbiter busy, blocks the start of a new request
//   mem_ready    in   one-cycle pulse, mem_data valid
//   mem_data     in   fetched instruction word
//   instr        out  head-of-queue instruction
//   instr_pc     out  PC of the head entry
//   instr_valid  out  head entry valid
//   instr_take   in   consume the head (ignored when instr_valid is low)
//   redirect     in   flush and restart fetching at redirect_pc
//   redirect_pc  in   new fetch PC
//   level        out  number of valid FIFO entries
// ---------------------------------------------------------------------------
module prefetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_busy,
  input  logic                     mem_ready,
  input  logic [INSTR_W-1:0]       mem_data,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_take,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  // IDLE: nothing outstanding. REQ: response will be kept.
  // DISCARD: response still owed by memory but must be dropped.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [INSTR_W-1:0]  word_q [DEPTH];
  logic [INSTR_W-1:0]  word_d [DEPTH];
  logic [ADDR_W-1:0]   tag_q  [DEPTH];
  logic [ADDR_W-1:0]   tag_d  [DEPTH];

  logic                bypass_s;
  logic                wr_s;
  logic                rd_s;

`ifdef PREFETCH_BYPASS_EN
  // Empty queue with a kept response arriving: hand it straight to the decoder.
  assign bypass_s = (level_q == LVL_ZERO) && (state_q == ST_REQ) && mem_ready && !redirect;
`else
  assign bypass_s = 1'b0;
`endif

  // A kept response is written unless the decoder already took it via bypass.
  assign wr_s = (state_q == ST_REQ) && mem_ready && !redirect && !(bypass_s && instr_take);
  // Head advances only on a real FIFO entry; redirect overrides a take.
  assign rd_s = instr_take && (level_q != LVL_ZERO) && !redirect;

  // Fetch sequencing: request issue, response completion and redirect handling.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          // No issue in the redirect cycle; the new PC is fetched next cycle.
          fetch_pc_d = redirect_pc;
        end else if (!mem_busy && (level_q < FULL_LVL)) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (mem_ready) begin
            // Response lands with the redirect: drop it, nothing left owed.
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (mem_ready) begin
          fetch_pc_d = fetch_pc_q + PC_ONE;
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and entry storage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    word_d  = word_q;
    tag_d   = tag_q;
    if (redirect) begin
      head_d  = PTR_ZERO;
      tail_d  = PTR_ZERO;
      level_d = LVL_ZERO;
    end else begin
      if (rd_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (wr_s) begin
        tail_d         = tail_q + PTR_ONE;
        word_d[tail_q] = mem_data;
        tag_d[tail_q]  = fetch_pc_q;
      end else begin
        tail_d = tail_q;
      end
      case ({wr_s, rd_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // State, request and FIFO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      head_q     <= PTR_ZERO;
      tail_q     <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      word_q     <= '{default: {INSTR_W{1'b0}}};
      tag_q      <= '{default: {ADDR_W{1'b0}}};
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      word_q     <= word_d;
      tag_q      <= tag_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign level    = level_q;

`ifdef PREFETCH_BYPASS_EN
  assign instr       = bypass_s ? mem_data   : word_q[head_q];
  assign instr_pc    = bypass_s ? fetch_pc_q : tag_q[head_q];
  assign instr_valid = bypass_s || (level_q != LVL_ZERO);
`else
  assign instr       = word_q[head_q];
  assign instr_pc    = tag_q[head_q];
  assign instr_valid = (level_q != LVL_ZERO);
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_prefetch_queue
//
// Bench for prefetch_queue (DEPTH=4, RESET_PC=0x0100). A memory model answers
// each request after a programmable latency with a word derived from the
// address. Kept responses are pushed to a scoreboard with the PC the bench
// expects; takes pop the scoreboard and compare instr/instr_pc. Occupancy and
// instr_valid are compared against the scoreboard every cycle.
// ---------------------------------------------------------------------------
module tb_prefetch_queue;

  localparam int          AW       = 16;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] START_PC = 16'h0100;

  logic          clk;
  logic          rst;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_busy;
  logic          mem_ready;
  logic [31:0]   mem_data;
  logic [31:0]   instr;
  logic [15:0]   instr_pc;
  logic          instr_valid;
  logic          instr_take;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic [2:0]    level;

  prefetch_queue #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC(START_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_busy(mem_busy),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_take(instr_take), .redirect(redirect), .redirect_pc(redirect_pc),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [15:0] pc;
  } entry_t;

  entry_t      sb_q[$];
  entry_t      pend_e;
  logic        pend_v;
  logic [15:0] exp_pc;
  logic [15:0] req_addr;
  logic [15:0] req_pc;
  logic        mem_active;
  logic        act_discard;
  int          lat;
  int          cnt;
  logic [15:0] req_log[$];
  int          checks_n;
  int          fails_n;
  int          max_level;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_n++;
    if (obs !== exp) begin
      fails_n++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  task automatic model_reset();
    sb_q.delete();
    pend_v      = 1'b0;
    exp_pc      = START_PC;
    mem_active  = 1'b0;
    act_discard = 1'b0;
    cnt         = 0;
    mem_ready   = 1'b0;
    mem_data    = 32'h0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, START_PC);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 16'h0);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_level", level, 3'd0);
  endtask

  // One clock: drive take/redirect, cross the edge, update the model,
  // run the per-cycle checks and advance the memory model.
  task automatic cycle(input logic tk, input logic rd, input logic [15:0] rpc);
    logic tk_fifo;
    logic tk_byp;
    logic byp_now;
    tk_fifo = 1'b0;
    tk_byp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
    byp_now = (sb_q.size() == 0) && pend_v && mem_ready;
`else
    byp_now = 1'b0;
`endif
    instr_take  = tk;
    redirect    = rd;
    redirect_pc = rpc;
    if (tk && !rd) begin
      if (sb_q.size() != 0) begin
        check_eq("take_word", instr, sb_q[0].word);
        check_eq("take_pc", instr_pc, sb_q[0].pc);
        tk_fifo = 1'b1;
      end else if (byp_now) begin
        check_eq("byp_word", instr, pend_e.word);
        check_eq("byp_pc", instr_pc, pend_e.pc);
        check_eq("byp_valid", instr_valid, 1'b1);
        tk_byp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rd) begin
      sb_q.delete();
      pend_v = 1'b0;
      exp_pc = rpc;
      if (mem_active) act_discard = 1'b1;
    end else begin
      if (tk_fifo) void'(sb_q.pop_front());
      if (pend_v) begin
        if (!tk_byp) sb_q.push_back(pend_e);
        exp_pc = exp_pc + 16'd1;
      end
      pend_v = 1'b0;
    end
    instr_take = 1'b0;
    redirect   = 1'b0;
    check_eq("level", level, sb_q.size());
    check_eq("valid", instr_valid, sb_q.size() != 0);
    if (int'(level) > max_level) max_level = int'(level);
    mem_ready = 1'b0;
    if (mem_active) begin
      check_eq("addr_stable", mem_addr, req_addr);
      check_eq("req_held", mem_req, 1'b1);
      cnt++;
      if (cnt >= lat) begin
        mem_ready  = 1'b1;
        mem_data   = data_of(req_addr);
        mem_active = 1'b0;
        if (!act_discard) begin
          pend_v = 1'b1;
          pend_e = '{word: data_of(req_pc), pc: req_pc};
        end
      end
    end else if (mem_req) begin
      check_eq("req_addr", mem_addr, exp_pc);
      req_addr    = mem_addr;
      req_pc      = exp_pc;
      req_log.push_back(mem_addr);
      mem_active  = 1'b1;
      act_discard = 1'b0;
      cnt         = 0;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    checks_n    = 0;
    fails_n     = 0;
    max_level   = 0;
    lat         = 2;
    rst         = 1'b1;
    mem_busy    = 1'b0;
    instr_take  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    check_reset_outputs();
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    rst = 1'b1;

    // Take on an empty queue is ignored; fill to DEPTH from RESET_PC.
    cycle(1'b1, 1'b0, 16'h0);
    check_eq("empty_take_level", level, 3'd0);
    n = 0;
    while (sb_q.size() < 4 && n < 200) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("fill_in_time", n < 200, 1'b1);
    check_eq("fill_level", level, 3'd4);
    check_eq("fill_req_count", req_log.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("fill_addr", req_log[i], START_PC + 16'(i));
    repeat (10) cycle(1'b0, 1'b0, 16'h0);
    check_eq("full_no_5th_req", req_log.size(), 4);
    check_eq("full_req_low", mem_req, 1'b0);

    // Single take on a full queue: exactly one refill to 0x0104.
    cycle(1'b1, 1'b0, 16'h0);
    check_eq("take_level3", level, 3'd3);
    n = 0;
    while (sb_q.size() < 4 && n < 100) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("refill_in_time", n < 100, 1'b1);
    check_eq("refill_count", req_log.size(), 5);
    check_eq("refill_addr", req_log[4], 16'h0104);

    // Drain across pointer wrap while 0x0105 is fetched, then redirect mid-request.
    lat = 4;
    repeat (4) cycle(1'b1, 1'b0, 16'h0);
    check_eq("in_req_0105", mem_active && !pend_v, 1'b1);
    check_eq("req_0105", req_log[req_log.size()-1], 16'h0105);
    cycle(1'b0, 1'b1, 16'h2000);
    check_eq("redir_level0", level, 3'd0);
    check_eq("redir_valid0", instr_valid, 1'b0);
    n = 0;
    while (sb_q.size() == 0 && n < 100) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("redir_fill_in_time", n < 100, 1'b1);
    check_eq("redir_first_pc", instr_pc, 16'h2000);
    check_eq("redir_req_addr", req_log[req_log.size()-1], 16'h2000);
    lat = 2;
    cycle(1'b1, 1'b0, 16'h0);

    // mem_busy held for 5 cycles in IDLE blocks any new request.
    n = 0;
    while (!pend_v && n < 50) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("busy_setup_in_time", n < 50, 1'b1);
    mem_busy = 1'b1;
    base = req_log.size();
    repeat (5) cycle(1'b1, 1'b0, 16'h0);
    check_eq("busy_no_req", req_log.size(), base);
    check_eq("busy_req_low", mem_req, 1'b0);
    mem_busy = 1'b0;
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("busy_release_req", mem_req, 1'b1);
    check_eq("busy_release_count", req_log.size(), base + 1);

    // Fetch PC wraps from 0xFFFF to 0x0000.
    cycle(1'b0, 1'b1, 16'hFFFE);
    base = req_log.size();
    n = 0;
    while (req_log.size() < base + 3 && n < 100) begin cycle(1'b1, 1'b0, 16'h0); n++; end
    check_eq("wrap_in_time", n < 100, 1'b1);
    check_eq("wrap_addr0", req_log[base], 16'hFFFE);
    check_eq("wrap_addr1", req_log[base+1], 16'hFFFF);
    check_eq("wrap_addr2", req_log[base+2], 16'h0000);
    repeat (8) cycle(1'b1, 1'b0, 16'h0);

    // Asynchronous reset in the middle of a request.
    n = 0;
    while (!(mem_active && cnt == 1) && n < 50) begin cycle(1'b1, 1'b0, 16'h0); n++; end
    check_eq("midreq_in_time", n < 50, 1'b1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    base = req_log.size();
    n = 0;
    while (req_log.size() == base && n < 20) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("post_rst_in_time", n < 20, 1'b1);
    check_eq("post_rst_addr", req_log[req_log.size()-1], START_PC);

    // Response into an empty queue: bypass or one-cycle latency.
    cycle(1'b0, 1'b1, 16'h3000);
    n = 0;
    while (!(pend_v && sb_q.size() == 0) && n < 50) begin cycle(1'b0, 1'b0, 16'h0); n++; end
    check_eq("empty_ready_in_time", n < 50, 1'b1);
`ifdef PREFETCH_BYPASS_EN
    check_eq("bypass_valid", instr_valid, 1'b1);
    check_eq("bypass_pc", instr_pc, 16'h3000);
    cycle(1'b1, 1'b0, 16'h0);
    check_eq("bypass_take_level", level, 3'd0);
`else
    check_eq("no_bypass_valid", instr_valid, 1'b0);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("latency_valid", instr_valid, 1'b1);
    check_eq("latency_pc", instr_pc, 16'h3000);
`endif

    check_eq("never_overflow", max_level <= DEPTH, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
